// File: rtl/branch_cmp_unit_pkg.sv
// Shared definitions for the branch-condition unit.
// Holds the compare-mode encoding used by the compare core, the top level
// and the controller's branch decoder.
package branch_cmp_unit_pkg;

    // Compare modes as they appear on the 3-bit op port.
    typedef enum logic [2:0] {
        CMP_EQ  = 3'd0,  // A == B
        CMP_NE  = 3'd1,  // A != B
        CMP_LEZ = 3'd2,  // A <= 0 (signed)
        CMP_GTZ = 3'd3,  // A >  0 (signed)
        CMP_LTZ = 3'd4,  // A <  0 (signed)
        CMP_GEZ = 3'd5,  // A >= 0 (signed)
        CMP_LT  = 3'd6,  // signed   A < B
        CMP_LTU = 3'd7   // unsigned A < B
    } cmp_op_e;

    localparam int OP_W = 3;

endpackage

// File: rtl/branch_cmp_unit_cmp_core.sv
// cmp_core: purely combinational branch-condition evaluator.
// Ports:
//   op   in  3      compare mode (cmp_op_e encoding)
//   A    in  WIDTH  operand rs
//   B    in  WIDTH  operand rt (unused by the zero-compare modes)
//   cond out 1      condition result
module cmp_core
    import branch_cmp_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             cond
);

    logic a_neg;
    logic a_zero;

    // Zero-compares treat A as two's complement: the MSB is the sign.
    assign a_neg  = A[WIDTH-1];
    assign a_zero = (A == '0);

    always_comb begin
        // NOTE: default assignment first so every path drives cond and no latch is inferred.
        cond = 1'b0;
        case (cmp_op_e'(op))
            CMP_EQ:  cond = (A == B);
            CMP_NE:  cond = (A != B);
            CMP_LEZ: cond = a_neg | a_zero;
            CMP_GTZ: cond = ~a_neg & ~a_zero;
            CMP_LTZ: cond = a_neg;
            CMP_GEZ: cond = ~a_neg;
            CMP_LT:  cond = ($signed(A) < $signed(B));
            CMP_LTU: cond = (A < B);
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_cmp_unit.sv
// branch_cmp_unit: branch-condition unit for the MIPS pipeline.
// Provides a combinational condition for early (D-stage) resolution, a
// registered stall/flush-aware result with misprediction flag, and three
// saturating statistics counters.
// Ports:
//   clk         in   1      rising-edge clock
//   reset       in   1      synchronous active-low reset
//   in_valid    in   1      A/B/op/pred_taken describe a real branch
//   op          in   3      compare mode
//   A, B        in   WIDTH  operands (already forwarded)
//   pred_taken  in   1      front-end prediction
//   hold        in   1      stall: registered state keeps its value
//   flush       in   1      squash: registered result cleared (beats hold)
//   clr_cnt     in   1      synchronous clear of all counters (beats accept)
//   cond        out  1      combinational condition
//   res_valid   out  1      registered: a result is held
//   taken       out  1      registered: resolved taken
//   mispredict  out  1      registered: outcome differs from prediction
//   br_cnt      out  CNT_W  branches resolved (saturating)
//   taken_cnt   out  CNT_W  branches taken (saturating)
//   miss_cnt    out  CNT_W  mispredictions (saturating)
module branch_cmp_unit
    import branch_cmp_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             pred_taken,
    input  logic             hold,
    input  logic             flush,
    input  logic             clr_cnt,
    output logic             cond,
    output logic             res_valid,
    output logic             taken,
    output logic             mispredict,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic accept;
    logic miss;

    cmp_core #(.WIDTH(WIDTH)) u_cmp_core (
        .op   (op),
        .A    (A),
        .B    (B),
        .cond (cond)
    );

    // A branch is consumed only when neither squashed nor stalled.
    assign accept = in_valid & ~flush & ~hold;
    assign miss   = cond ^ pred_taken;

    // Result register: reset > flush > hold > load.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            res_valid  <= 1'b0;
            taken      <= 1'b0;
            mispredict <= 1'b0;
        end else if (flush) begin
            res_valid  <= 1'b0;
            taken      <= 1'b0;
            mispredict <= 1'b0;
        end else if (!hold) begin
            res_valid  <= in_valid;
            taken      <= in_valid & cond;
            mispredict <= in_valid & miss;
        end
    end

    // Saturating counters: clear wins over an accept on the same edge.
    always_ff @(posedge clk) begin
        if (!reset || clr_cnt) begin
            br_cnt <= '0;
        end else if (accept && br_cnt != CNT_MAX) begin
            br_cnt <= br_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clr_cnt) begin
            taken_cnt <= '0;
        end else if (accept && cond && taken_cnt != CNT_MAX) begin
            taken_cnt <= taken_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clr_cnt) begin
            miss_cnt <= '0;
        end else if (accept && miss && miss_cnt != CNT_MAX) begin
            miss_cnt <= miss_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_cmp_unit.sv
// Self-checking bench for branch_cmp_unit (WIDTH=32, CNT_W=4).
// Table-driven combinational compare checks followed by hand-written
// multi-cycle sequences for hold, flush, saturation, clear and reset.
module tb_branch_cmp_unit;
    import branch_cmp_unit_pkg::*;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             pred_taken;
    logic             hold;
    logic             flush;
    logic             clr_cnt;
    logic             cond;
    logic             res_valid;
    logic             taken;
    logic             mispredict;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] miss_cnt;

    int checks   = 0;
    int failures = 0;

    branch_cmp_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .op         (op),
        .A          (A),
        .B          (B),
        .pred_taken (pred_taken),
        .hold       (hold),
        .flush      (flush),
        .clr_cnt    (clr_cnt),
        .cond       (cond),
        .res_valid  (res_valid),
        .taken      (taken),
        .mispredict (mispredict),
        .br_cnt     (br_cnt),
        .taken_cnt  (taken_cnt),
        .miss_cnt   (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             exp_cond;
    } cmp_vec_t;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Check the full registered state against expected values.
    task automatic check_regs(input string tag, input logic rv, input logic tk, input logic mp,
                              input int bc, input int tc, input int mc);
        check({tag, ".res_valid"},  {31'd0, res_valid},  {31'd0, rv});
        check({tag, ".taken"},      {31'd0, taken},      {31'd0, tk});
        check({tag, ".mispredict"}, {31'd0, mispredict}, {31'd0, mp});
        check({tag, ".br_cnt"},     {28'd0, br_cnt},     bc);
        check({tag, ".taken_cnt"},  {28'd0, taken_cnt},  tc);
        check({tag, ".miss_cnt"},   {28'd0, miss_cnt},   mc);
    endtask

    // Advance one clock edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic p);
        in_valid   = v;
        op         = o;
        A          = a;
        B          = b;
        pred_taken = p;
    endtask

    cmp_vec_t vecs [$];

    initial begin
        // Test 2 vectors plus extra boundary operands.
        vecs.push_back('{"eq_same",   CMP_EQ,  32'h0000_1234, 32'h0000_1234, 1'b1});
        vecs.push_back('{"eq_diff",   CMP_EQ,  32'h0000_1234, 32'h0000_1235, 1'b0});
        vecs.push_back('{"lt_m1_1",   CMP_LT,  32'hFFFF_FFFF, 32'h0000_0001, 1'b1});
        vecs.push_back('{"ltu_m1_1",  CMP_LTU, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0});
        vecs.push_back('{"ltz_m1",    CMP_LTZ, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1});
        vecs.push_back('{"gez_m1",    CMP_GEZ, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0});
        vecs.push_back('{"lez_m1",    CMP_LEZ, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1});
        vecs.push_back('{"gtz_m1",    CMP_GTZ, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0});
        vecs.push_back('{"ne_m1_1",   CMP_NE,  32'hFFFF_FFFF, 32'h0000_0001, 1'b1});
        vecs.push_back('{"ne_same",   CMP_NE,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{"lez_zero",  CMP_LEZ, 32'h0000_0000, 32'h1234_5678, 1'b1});
        vecs.push_back('{"gtz_zero",  CMP_GTZ, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{"ltz_zero",  CMP_LTZ, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{"gez_zero",  CMP_GEZ, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{"gtz_one",   CMP_GTZ, 32'h0000_0001, 32'h0000_0000, 1'b1});
        vecs.push_back('{"lez_max",   CMP_LEZ, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0});
        vecs.push_back('{"lt_max_min",  CMP_LT,  32'h7FFF_FFFF, 32'h8000_0000, 1'b0});
        vecs.push_back('{"ltu_max_min", CMP_LTU, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1});
        vecs.push_back('{"lt_min_max",  CMP_LT,  32'h8000_0000, 32'h7FFF_FFFF, 1'b1});
        vecs.push_back('{"ltu_min_max", CMP_LTU, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0});
        vecs.push_back('{"lt_equal",    CMP_LT,  32'h0000_0005, 32'h0000_0005, 1'b0});

        reset   = 1'b0;
        hold    = 1'b0;
        flush   = 1'b0;
        clr_cnt = 1'b0;
        drive(1'b0, CMP_EQ, '0, '0, 1'b0);

        // Reset state.
        tick();
        tick();
        check_regs("reset", 1'b0, 1'b0, 1'b0, 0, 0, 0);
        // cond is live even while reset is asserted.
        check("cond_in_reset", {31'd0, cond}, 32'd1);
        reset = 1'b1;
        tick();

        // Combinational modes; in_valid=0 so nothing is consumed.
        foreach (vecs[i]) begin
            drive(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
            #1;
            check({"cond.", vecs[i].name}, {31'd0, cond}, {31'd0, vecs[i].exp_cond});
        end
        tick();
        check_regs("idle", 1'b0, 1'b0, 1'b0, 0, 0, 0);

        // Test 1: taken EQ branch predicted not-taken.
        drive(1'b1, CMP_EQ, 32'h1234, 32'h1234, 1'b0);
        #1;
        check("t1.cond", {31'd0, cond}, 32'd1);
        tick();
        check_regs("t1", 1'b1, 1'b1, 1'b1, 1, 1, 1);

        // Test 3: accept a correctly predicted taken branch, then stall 3 cycles.
        drive(1'b1, CMP_EQ, 32'h55, 32'h55, 1'b1);
        tick();
        check_regs("t3.accept", 1'b1, 1'b1, 1'b0, 2, 2, 1);
        hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, CMP_EQ, 32'h5 + c, 32'h6 + 2 * c, 1'b0);
            tick();
            check_regs($sformatf("t3.hold%0d", c), 1'b1, 1'b1, 1'b0, 2, 2, 1);
        end
        hold = 1'b0;
        drive(1'b0, CMP_EQ, 32'h0, 32'h0, 1'b0);
        tick();
        check_regs("t3.release", 1'b0, 1'b0, 1'b0, 2, 2, 1);

        // Test 4: load a result, then hold and flush together with a valid branch.
        drive(1'b1, CMP_NE, 32'h1, 32'h2, 1'b1);
        tick();
        check_regs("t4.load", 1'b1, 1'b1, 1'b0, 3, 3, 1);
        hold  = 1'b1;
        flush = 1'b1;
        drive(1'b1, CMP_EQ, 32'h7, 32'h7, 1'b0);
        tick();
        check_regs("t4.flush_hold", 1'b0, 1'b0, 1'b0, 3, 3, 1);
        hold = 1'b0;
        tick();
        check_regs("t4.flush_only", 1'b0, 1'b0, 1'b0, 3, 3, 1);
        flush = 1'b0;

        // Test 5: clear, then saturate all three counters.
        clr_cnt = 1'b1;
        drive(1'b0, CMP_EQ, 32'h0, 32'h0, 1'b0);
        tick();
        check_regs("t5.clear", 1'b0, 1'b0, 1'b0, 0, 0, 0);
        clr_cnt = 1'b0;
        drive(1'b1, CMP_GEZ, 32'h0000_0010, 32'h0, 1'b0);
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n == 14 || n == 15 || n == 20)
                check_regs($sformatf("t5.sat%0d", n), 1'b1, 1'b1, 1'b1,
                           (n > 15) ? 15 : n, (n > 15) ? 15 : n, (n > 15) ? 15 : n);
        end
        clr_cnt = 1'b1;
        tick();
        check_regs("t5.clr_accept", 1'b1, 1'b1, 1'b1, 0, 0, 0);
        clr_cnt = 1'b0;

        // Test 6: reset during a stream of branches while stalled.
        drive(1'b1, CMP_LTZ, 32'h8000_0000, 32'h0, 1'b0);
        tick();
        tick();
        check_regs("t6.stream", 1'b1, 1'b1, 1'b1, 2, 2, 2);
        reset = 1'b0;
        hold  = 1'b1;
        flush = 1'b1;
        tick();
        check_regs("t6.reset", 1'b0, 1'b0, 1'b0, 0, 0, 0);
        reset = 1'b1;
        hold  = 1'b0;
        flush = 1'b0;
        tick();
        check_regs("t6.restart", 1'b1, 1'b1, 1'b1, 1, 1, 1);
        // Not-taken outcome against a taken prediction.
        drive(1'b1, CMP_LTU, 32'h9, 32'h3, 1'b1);
        tick();
        check_regs("t6.nt_miss", 1'b1, 1'b0, 1'b1, 2, 1, 2);
        drive(1'b0, CMP_EQ, 32'h0, 32'h0, 1'b0);
        tick();
        check_regs("t6.idle", 1'b0, 1'b0, 1'b0, 2, 1, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
